// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with 1-cycle RAM and instruction queue; FETCH_MISALIGN_CHK_EN enables misaligned-redirect fault
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk_cpu,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] mem_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   tgt_pc;
    logic          tgt_bad;
    logic          inflight;
    logic [31:0]   req_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          issue;
    logic          push;
    logic          pop;
    logic [31:0]   q_inst [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];

`ifdef FETCH_MISALIGN_CHK_EN
    assign tgt_pc  = redirect_pc;
    assign tgt_bad = |redirect_pc[1:0];
`else
    assign tgt_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign tgt_bad = 1'b0;
`endif

    always_ff @(posedge clk_cpu) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect) state_nxt = tgt_bad ? FAULT : RUN;
    end

    // Issue only when the queue can absorb the word already in flight plus this one.
    always_comb begin
        pop   = out_valid & out_ready;
        push  = inflight & ~redirect & (state == RUN);
        issue = (state == RUN) & ~redirect &
                (((CW + 1)'(count) + (CW + 1)'(inflight)) < (QD + (CW + 1)'(pop)));
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            req_pc   <= 32'h0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            if (!tgt_bad) pc <= tgt_pc;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (!reset && push) begin
            q_inst[wr_ptr] <= mem_inst;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic        fault_r;
    logic [31:0] fault_pc_r;

    // fault_pc keeps the last offending target after recovery.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            fault_r    <= 1'b0;
            fault_pc_r <= 32'h0;
        end else if (redirect) begin
            fault_r <= tgt_bad;
            if (tgt_bad) fault_pc_r <= redirect_pc;
        end
    end

    assign fault    = fault_r;
    assign fault_pc = fault_pc_r;
`else
    assign fault    = 1'b0;
    assign fault_pc = 32'h0;
`endif

    always_comb begin
        out_valid = (count != '0);
        out_inst  = out_valid ? q_inst[rd_ptr] : 32'h0;
        out_pc    = out_valid ? q_pc[rd_ptr]   : 32'h0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (boot, backpressure, redirect, fault, pc wrap)
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] mem_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    logic [31:0] held_pc;

    fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(2)) dut (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .pc         (pc),
        .mem_inst   (mem_inst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .fault      (fault),
        .fault_pc   (fault_pc)
    );

    always #5 clk_cpu = ~clk_cpu;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Single-cycle-latency instruction RAM model.
    always @(posedge clk_cpu) mem_inst <= inst_of(pc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] start);
        sb.delete();
        for (int i = 0; i < 32; i++) sb.push_back(start + 32'(4 * i));
    endtask

    task automatic sample();
        logic [31:0] exp;
        @(negedge clk_cpu);
        if (out_valid === 1'b1) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", out_pc, 32'hDEAD_DEAD);
                end else begin
                    exp = sb.pop_front();
                    check("out_pc", out_pc, exp);
                    check("out_inst", out_inst, inst_of(exp));
                end
            end
        end else begin
            check("idle_out_pc", out_pc, 32'h0);
            check("idle_out_inst", out_inst, 32'h0);
        end
    endtask

    task automatic advance();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_redirect(input logic [31:0] addr);
        redirect    = 1'b1;
        redirect_pc = addr;
        sample();
        sb.delete();
`ifdef FETCH_MISALIGN_CHK_EN
        if (addr[1:0] == 2'b00) push_stream(addr);
`else
        push_stream(addr & 32'hFFFF_FFFC);
`endif
        advance();
        redirect = 1'b0;
    endtask

    task automatic expect_restart(input logic [31:0] target);
        sample();
        check("rd_pc", pc, target);
        check("rd_gap1", 32'(out_valid), 32'd0);
        advance();
        sample();
        check("rd_gap2", 32'(out_valid), 32'd0);
        advance();
        sample();
        check("rd_first_valid", 32'(out_valid), 32'd1);
        check("rd_first_pc", out_pc, target);
        advance();
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0500;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk_cpu);
        @(negedge clk_cpu);
        check("rst_pc", pc, RST_PC);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_pc", fault_pc, 32'h0);
        advance();
        reset    = 1'b0;
        redirect = 1'b0;
        push_stream(RST_PC);

        for (int k = 0; k < 5; k++) begin
            sample();
            check("boot_valid", 32'(out_valid), (k >= 2) ? 32'd1 : 32'd0);
            check("boot_pc", pc, RST_PC + 32'(4 * k));
            advance();
        end

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_head_pc", out_pc, 32'h0000_010C);
            check("bp_head_inst", out_inst, inst_of(32'h0000_010C));
            check("bp_pc_stall", pc, 32'h0000_0114);
            advance();
        end
        out_ready = 1'b1;
        repeat (6) cycle();

        do_redirect(32'h0000_0200);
        expect_restart(32'h0000_0200);
        repeat (3) cycle();

        held_pc = pc;
        do_redirect(32'h0000_0202);
`ifdef FETCH_MISALIGN_CHK_EN
        for (int k = 0; k < 4; k++) begin
            sample();
            check("flt_fault", 32'(fault), 32'd1);
            check("flt_fault_pc", fault_pc, 32'h0000_0202);
            check("flt_valid", 32'(out_valid), 32'd0);
            check("flt_pc_held", pc, held_pc);
            advance();
        end
        do_redirect(32'h0000_0300);
        sample();
        check("flt_cleared", 32'(fault), 32'd0);
        advance();
        sample();
        advance();
        sample();
        check("flt_resume_valid", 32'(out_valid), 32'd1);
        check("flt_resume_pc", out_pc, 32'h0000_0300);
        advance();
`else
        sample();
        check("nochk_pc", pc, 32'h0000_0200);
        check("nochk_fault", 32'(fault), 32'd0);
        check("nochk_fault_pc", fault_pc, 32'h0);
        advance();
        sample();
        advance();
        sample();
        check("nochk_first_valid", 32'(out_valid), 32'd1);
        check("nochk_first_pc", out_pc, 32'h0000_0200);
        advance();
        repeat (2) cycle();
        do_redirect(32'h0000_0300);
        expect_restart(32'h0000_0300);
`endif
        repeat (3) cycle();

        do_redirect(32'hFFFF_FFF8);
        expect_restart(32'hFFFF_FFF8);
        sample();
        check("wrap_pc_fffc", out_pc, 32'hFFFF_FFFC);
        advance();
        sample();
        check("wrap_pc_0", out_pc, 32'h0000_0000);
        check("wrap_fault", 32'(fault), 32'd0);
        advance();
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
